// File: rtl/apu_pkg.sv
// Shared APU constants: register offsets and the length-counter load table.
// Imported by the square-channel register block and its length counters.
package apu_pkg;

  localparam logic [4:0] OFS_SQ1_LEN = 5'h03;
  localparam logic [4:0] OFS_SQ2_LEN = 5'h07;
  localparam logic [4:0] OFS_STATUS  = 5'h15;

  localparam logic [7:0] LEN_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,
    8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,
    8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,
    8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,
    8'd16,  8'd28,  8'd32,  8'd30
  };

  function automatic logic [7:0] len_lookup(
    input logic [4:0] idx
  );
    return LEN_TABLE[idx];
  endfunction

endpackage

// File: rtl/apu_length_counter.sv
// One square-channel length counter: load, halt-gated decrement, clear.
// Clear beats load, load beats the half-frame decrement.
module apu_length_counter #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             tick,
  input  logic             halt,
  input  logic             clear,
  output logic [LEN_W-1:0] count,
  output logic             active
);

  logic [LEN_W-1:0] count_q;
  logic [LEN_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (tick && !halt && count_q != '0) begin
      count_d = count_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count  = count_q;
  assign active = |count_q;

endmodule

// File: rtl/apu_square_regif.sv
// CPU register file for both square channels plus their length counters.
// A write is accepted when valid meets ready; ready then drops for one cycle.
module apu_square_regif
  import apu_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_valid,
  output logic        bus_ready,
  input  logic [4:0]  bus_addr,
  input  logic [7:0]  bus_wdata,
  input  logic        half_frame_tick,
  output logic [31:0] sq1_regs,
  output logic [31:0] sq2_regs,
  output logic        sq1_restart,
  output logic        sq2_restart,
  output logic [1:0]  len_active
);

  logic [7:0] regs_q [8];
  logic [7:0] regs_d [8];
  logic [1:0] en_q, en_d;
  logic       ready_q, ready_d;
  logic       rs1_q, rs1_d;
  logic       rs2_q, rs2_d;
  logic [1:0] act_q, act_d;

  logic             acc;
  logic             load1, load2;
  logic [LEN_W-1:0] load_val;
  logic [LEN_W-1:0] cnt1, cnt2;
  logic             act1, act2;

  always_comb begin
    acc     = bus_valid & ready_q;
    ready_d = ~acc;
    regs_d  = regs_q;
    en_d    = en_q;
    if (acc && bus_addr[4:3] == 2'b00) begin
      regs_d[bus_addr[2:0]] = bus_wdata;
    end
    if (acc && bus_addr == OFS_STATUS) begin
      en_d = bus_wdata[1:0];
    end
    rs1_d    = acc && bus_addr == OFS_SQ1_LEN;
    rs2_d    = acc && bus_addr == OFS_SQ2_LEN;
    load1    = rs1_d & en_q[0];
    load2    = rs2_d & en_q[1];
    load_val = LEN_W'(len_lookup(bus_wdata[7:3]));
    act_d    = {act2, act1};
  end

  // Clearing from en_d zeroes the counter on the same edge en drops.
  apu_length_counter #(.LEN_W(LEN_W)) u_len1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load1),
    .load_val (load_val),
    .tick     (half_frame_tick),
    .halt     (regs_q[0][5]),
    .clear    (~en_d[0]),
    .count    (cnt1),
    .active   (act1)
  );

  apu_length_counter #(.LEN_W(LEN_W)) u_len2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load2),
    .load_val (load_val),
    .tick     (half_frame_tick),
    .halt     (regs_q[4][5]),
    .clear    (~en_d[1]),
    .count    (cnt2),
    .active   (act2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      en_q    <= '0;
      ready_q <= 1'b0;
      rs1_q   <= 1'b0;
      rs2_q   <= 1'b0;
      act_q   <= '0;
    end else begin
      for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
      en_q    <= en_d;
      ready_q <= ready_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      act_q   <= act_d;
    end
  end

  assign bus_ready   = ready_q;
  assign sq1_regs    = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};
  assign sq2_regs    = {regs_q[7], regs_q[6], regs_q[5], regs_q[4]};
  assign sq1_restart = rs1_q;
  assign sq2_restart = rs2_q;
  assign len_active  = act_q;

endmodule
